// File: rtl/ddr_key_conditioner.sv
// ddr_key_conditioner: four independent key lanes. Each lane has a 2-flop
// synchronizer and a debounce FSM that produces a registered one-cycle
// press strobe and a registered held level.
// Optional feature: define KEY_AUTOREPEAT_EN to re-strobe press while a key
// stays down, once every REPEAT_CYCLES cycles.
//
// Handshake note: there is no valid/ready traffic here. press[i] is a
// single-cycle event strobe and held[i] is a level; neither can be stalled.
// Each lane's FSM register (g_lane[i].state_q) is a named enum so checkers
// can bind to it directly.
module ddr_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] key_n,
  output logic [3:0] press,
  output logic [3:0] held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  // Reject out-of-range configurations at elaboration.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 ||
      REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_param
    $error("ddr_key_conditioner: parameter out of legal range");
  end

  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  // Two-flop synchronizer; resets to all-released (key_n high).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;
    logic          held_q;
    logic          s;

    // s = 1 means the synchronized key is pressed.
    assign s = ~sync2_q[i];

`ifdef KEY_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_q;
`endif

    // Debounce FSM with registered press/held outputs.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
        press_q <= 1'b0;
        held_q  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rep_q   <= '0;
`endif
      end else begin
        press_q <= 1'b0;
        case (state_q)
          RELEASED: begin
            if (s) begin
              state_q <= PRESS_WAIT;
              cnt_q   <= CNT_ONE;
            end
          end
          PRESS_WAIT: begin
            if (!s) begin
              state_q <= RELEASED;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
              press_q <= 1'b1;
              held_q  <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
              rep_q   <= '0;
`endif
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          PRESSED: begin
            if (!s) begin
              state_q <= RELEASE_WAIT;
              cnt_q   <= CNT_ONE;
            end else begin
`ifdef KEY_AUTOREPEAT_EN
              // Repeat strobe fires on the edge that sees the counter at its
              // last value, giving an exact REPEAT_CYCLES period.
              if (rep_q == REP_LAST) begin
                rep_q   <= '0;
                press_q <= 1'b1;
              end else begin
                rep_q <= rep_q + 1'b1;
              end
`endif
            end
          end
          RELEASE_WAIT: begin
            if (s) begin
              // Release bounce: go back to PRESSED silently; repeat count kept.
              state_q <= PRESSED;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= RELEASED;
              cnt_q   <= '0;
              held_q  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
              rep_q   <= '0;
`endif
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            held_q  <= 1'b0;
          end
        endcase
      end
    end

    assign press[i] = press_q;
    assign held[i]  = held_q;
  end

endmodule

// File: tb/tb_ddr_key_conditioner.sv
// Testbench for ddr_key_conditioner: directed scenarios plus randomized
// per-lane toggling, checked against a run-length debounce model.
module tb_ddr_key_conditioner;

  localparam int DEB = 4;
  localparam int REP = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic [3:0] press;
  logic [3:0] held;

  always #5 clk = ~clk;

  ddr_key_conditioner #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_n),
    .press   (press),
    .held    (held)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // s at an edge is the inverse of key_n sampled two edges earlier. A lane
  // toggles its held level once s has disagreed with it for DEB consecutive
  // edges; a rising toggle is a press.
  logic [3:0] key_hist[$];
  int         run[4];
  logic [3:0] m_held;
`ifdef KEY_AUTOREPEAT_EN
  int         rep[4];
`endif
  logic [7:0] exp_q[$];

  task automatic model_reset();
    key_hist.delete();
    key_hist.push_back(4'hF);
    key_hist.push_back(4'hF);
    m_held = 4'h0;
    for (int i = 0; i < 4; i++) begin
      run[i] = 0;
`ifdef KEY_AUTOREPEAT_EN
      rep[i] = 0;
`endif
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
      exp_q.delete();
      exp_q.push_back(8'h00);
    end else begin
      logic [3:0] s;
      logic [3:0] p;
      s = ~key_hist.pop_front();
      key_hist.push_back(key_n);
      p = 4'h0;
      for (int i = 0; i < 4; i++) begin
        if (s[i] == m_held[i]) begin
`ifdef KEY_AUTOREPEAT_EN
          if (m_held[i] && run[i] == 0) begin
            if (rep[i] == REP - 1) begin
              rep[i] = 0;
              p[i] = 1'b1;
            end else begin
              rep[i]++;
            end
          end
`endif
          run[i] = 0;
        end else begin
          run[i]++;
          if (run[i] == DEB) begin
            m_held[i] = ~m_held[i];
            run[i] = 0;
`ifdef KEY_AUTOREPEAT_EN
            rep[i] = 0;
`endif
            if (m_held[i]) p[i] = 1'b1;
          end
        end
      end
      exp_q.push_back({p, m_held});
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check("sb_press_held", 32'({press, held}), 32'(e));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts negedges after the current point until lane's press/held match
  // the requested level; returns 0 if it never happens within the budget.
  task automatic edges_until(input int lane, input bit use_press, input bit level,
                             input int budget, output int edge_no);
    edge_no = 0;
    for (int e = 1; e <= budget; e++) begin
      @(negedge clk);
      if (((use_press ? press[lane] : held[lane]) == level) && edge_no == 0)
        edge_no = e;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e1, e2, cnt_p, cnt_h;
    model_reset();

    // Reset and idle
    reset_n = 1'b0;
    idle(3);
    check("rst_press", 32'(press), 32'h0);
    check("rst_held", 32'(held), 32'h0);
    #2 reset_n = 1'b1;
    cnt_p = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (press != 4'h0 || held != 4'h0) cnt_p++;
    end
    check("idle_quiet", 32'(cnt_p), 32'd0);

    // Lane 0: latency of press and release
    key_n[0] = 1'b0;
    cnt_p = 0; e1 = 0; e2 = 0;
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      if (press[0]) cnt_p++;
      if (press[0] && e1 == 0) e1 = e;
      if (held[0] && e2 == 0) e2 = e;
    end
    check("l0_press_latency", 32'(e1), 32'(DEB + 2));
    check("l0_held_rise", 32'(e2), 32'(DEB + 2));
`ifndef KEY_AUTOREPEAT_EN
    check("l0_press_once", 32'(cnt_p), 32'd1);
`endif
    key_n[0] = 1'b1;
    edges_until(0, 1'b0, 1'b0, 20, e1);
    check("l0_release_latency", 32'(e1), 32'(DEB + 2));
    idle(5);

    // Lane 1: short pulse is rejected
    key_n[1] = 1'b0;
    idle(DEB - 1);
    key_n[1] = 1'b1;
    cnt_p = 0; cnt_h = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (press[1]) cnt_p++;
      if (held[1]) cnt_h++;
    end
    check("l1_glitch_press", 32'(cnt_p), 32'd0);
    check("l1_glitch_held", 32'(cnt_h), 32'd0);

    // Lane 1: one-cycle release bounce keeps held with no new press
    key_n[1] = 1'b0;
    idle(DEB + 2 + 10);
    check("l1_held_before_bounce", 32'(held[1]), 32'd1);
    key_n[1] = 1'b1;
    @(negedge clk);
    key_n[1] = 1'b0;
    cnt_p = 0; cnt_h = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (press[1]) cnt_p++;
      if (!held[1]) cnt_h++;
    end
    check("l1_bounce_no_press", 32'(cnt_p), 32'd0);
    check("l1_bounce_held_low", 32'(cnt_h), 32'd0);
    key_n[1] = 1'b1;
    idle(10);

    // All lanes together
    key_n = 4'h0;
    cnt_p = 0; cnt_h = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (press == 4'hF) cnt_p++;
      if (press != 4'h0) cnt_h++;
    end
    check("all_press_together", 32'(cnt_p), 32'd1);
    check("all_press_cycles", 32'(cnt_h), 32'd1);
    key_n = 4'hF;
    idle(10);

    // Lane 2: reset mid-press, then requalify
    key_n[2] = 1'b0;
    idle(DEB + 5);
    check("l2_held_pre_reset", 32'(held[2]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("l2_reset_held", 32'(held), 32'h0);
    check("l2_reset_press", 32'(press), 32'h0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    cnt_p = 0; e1 = 0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (press[2]) cnt_p++;
      if (press[2] && e1 == 0) e1 = e;
    end
    check("l2_repress_latency", 32'(e1), 32'(DEB + 2));
    check("l2_repress_once", 32'(cnt_p), 32'd1);
    key_n[2] = 1'b1;
    idle(10);

`ifdef KEY_AUTOREPEAT_EN
    // Lane 0 auto-repeat over 60 cycles
    begin
      int edges[$];
      key_n[0] = 1'b0;
      for (int e = 1; e <= 60; e++) begin
        @(negedge clk);
        if (press[0]) edges.push_back(e);
      end
      check("rep_count", 32'(edges.size()), 32'd4);
      for (int k = 0; k < 4; k++)
        check("rep_edge", 32'((k < edges.size()) ? edges[k] : 0),
              32'(DEB + 2 + k * REP));
      key_n[0] = 1'b1;
      idle(10);
    end
`endif

    // Randomized per-lane toggling with bounce-length and stable intervals
    begin
      int timer[4];
      for (int i = 0; i < 4; i++) timer[i] = $urandom_range(1, 10);
      for (int c = 0; c < 800; c++) begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          timer[i]--;
          if (timer[i] <= 0) begin
            key_n[i] = ~key_n[i];
            timer[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DEB)
                                                    : $urandom_range(DEB + 2, 40);
          end
        end
        if (c == 400) begin
          #2 reset_n = 1'b0;
          @(negedge clk);
          #2 reset_n = 1'b1;
        end
      end
      key_n = 4'hF;
      idle(12);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_key_conditioner.md
DDR_KEY_CONDITIONER -- requirements
Module: ddr_key_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, giving consecutive stable synchronized cycles to accept a press or release; legal range 2..255.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 16, giving auto-repeat period in cycles; legal range 2..65535; used only when KEY_AUTOREPEAT_EN is defined.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all flops rise-edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port key_n, input, 4 bits: raw asynchronous KEY lines; 0 means pressed; bit i is lane i.
REQ-006 SHALL have port press, output, 4 bits: one-cycle press strobe per lane, registered.
REQ-007 SHALL have port held, output, 4 bits: debounced pressed level per lane, registered.

Function
REQ-008 SHALL treat the four lanes as identical and independent, with no shared state; any combination of press bits may assert in the same cycle.
REQ-009 SHALL pass each key_n bit through a 2-flop synchronizer, then invert it to give s (1 = pressed).
REQ-010 SHALL run a per-lane FSM with states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a debounce counter of $clog2(DEBOUNCE_CYCLES)+1 bits.
REQ-011 In RELEASED: if s=1, go to PRESS_WAIT with count 1; otherwise stay.
REQ-012 In PRESS_WAIT: if s=0, go to RELEASED with count 0; if count==DEBOUNCE_CYCLES-1, go to PRESSED; otherwise increment count.
REQ-013 On the PRESS_WAIT->PRESSED transition, press[i] and held[i] SHALL assert on the same edge; press[i] is high for exactly one cycle.
REQ-014 Press latency SHALL be DEBOUNCE_CYCLES+1 rising edges after the first edge that samples key_n[i]=0, given key_n[i] stays low throughout.
REQ-015 In PRESSED: if s=0, go to RELEASE_WAIT with count 1; otherwise stay.
REQ-016 In RELEASE_WAIT: if s=1, return to PRESSED with no press strobe; if count==DEBOUNCE_CYCLES-1, go to RELEASED and deassert held[i]; otherwise increment count.
REQ-017 held[i] SHALL be 1 exactly in PRESSED and RELEASE_WAIT; release latency is symmetric to REQ-014.
REQ-018 A low pulse on key_n[i] lasting DEBOUNCE_CYCLES-1 or fewer sampled cycles SHALL produce no press and no held change.
REQ-019 Bouncing input SHALL restart qualification from count 1 on each re-entry to PRESS_WAIT; counters never wrap.

Reset
REQ-020 While reset_n=0, all state SHALL be forced asynchronously: synchronizer flops = 1 (released), FSM = RELEASED, counters = 0, press = 4'b0000, held = 4'b0000.
REQ-021 Reset asserted mid-press SHALL clear outputs immediately; after deassertion, a still-held key SHALL requalify per REQ-014 and produce exactly one press.

Configuration
REQ-022 With macro KEY_AUTOREPEAT_EN defined, each lane SHALL run a repeat counter of $clog2(REPEAT_CYCLES)+1 bits: zeroed on entry to PRESSED, incremented each cycle in PRESSED, and on reaching REPEAT_CYCLES-1 it SHALL pulse press[i] for one cycle and return to 0.
REQ-023 With KEY_AUTOREPEAT_EN defined, the repeat counter SHALL hold its value during RELEASE_WAIT and SHALL reset to 0 on reaching RELEASED.
REQ-024 Without KEY_AUTOREPEAT_EN, no repeat logic SHALL exist and press SHALL pulse only per REQ-013.

Verification
REQ-025 Defaults; reset_n 0->1; key_n=4'b1111 for 20 cycles -> press=0 and held=0 throughout.
REQ-026 key_n[0] held low 30 cycles -> press[0] high for exactly one cycle, 5 edges after the first low sample; held[0] rises on the same edge; held[0] falls 5 edges after key_n[0] returns high.
REQ-027 key_n[1] low for 3 cycles, then high -> no press[1] and held[1] stays 0; a 1-cycle high glitch after 10 cycles pressed -> held[1] stays 1 with no second press.
REQ-028 key_n[3:0] go 4'b1111->4'b0000 on one edge -> press=4'b1111 for exactly one cycle.
REQ-029 reset_n pulsed low for 1 cycle while key_n[2] is pressed and held[2]=1 -> held[2]=0 immediately; a new press[2] pulse follows 5 edges after reset_n deasserts.
REQ-030 With KEY_AUTOREPEAT_EN defined, key_n[0] held low 60 cycles -> press[0] pulses at the initial edge, then at +16, +32 and +48 cycles.
